regfile_scoreboard_wb: RTL and testbench

Write-back stage register file with a per-register pending-write scoreboard, sitting between instruction decode and the end of the pipeline. Decode presents source and destination registers each cycle. The block returns operand data with write-back bypass, raises a stall when a source is still pending, and reserves the destination on issue. Write-back selects ALU or memory data, writes the register, and releases one reservation. Per-register counters replace single busy flags, so back-to-back writes to the same register (WAW) never release a hazard early.

---
 rtl/regfile_scoreboard_wb_if.sv | 39 +++
 rtl/regfile_scoreboard_wb.sv | 122 ++++++++++++
 tb/tb_regfile_scoreboard_wb.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_wb_if.sv
// Decode / write-back bundle for the scoreboarded register file.
// The master side is the pipeline; the slave side is the register file.
interface regfile_scoreboard_wb_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  id_valid;
  logic [4:0]            id_rs_addr;
  logic [4:0]            id_rt_addr;
  logic [4:0]            id_dst_addr;
  logic                  id_reg_write;
  logic                  wb_valid;
  logic                  wb_reg_write;
  logic                  wb_mem_to_reg;
  logic [4:0]            wb_addr;
  logic [DATA_WIDTH-1:0] alu_data_out;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic [DATA_WIDTH-1:0] reg_file_rd_data1;
  logic [DATA_WIDTH-1:0] reg_file_rd_data2;
  logic                  hazard_stall;
  logic                  issue_accept;
  logic [31:0]           pending_vec;
  logic                  wb_error;

  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_dst_addr, id_reg_write,
    output wb_valid, wb_reg_write, wb_mem_to_reg, wb_addr,
    output alu_data_out, mem_data_out,
    input  reg_file_rd_data1, reg_file_rd_data2,
    input  hazard_stall, issue_accept, pending_vec, wb_error
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_dst_addr, id_reg_write,
    input  wb_valid, wb_reg_write, wb_mem_to_reg, wb_addr,
    input  alu_data_out, mem_data_out,
    output reg_file_rd_data1, reg_file_rd_data2,
    output hazard_stall, issue_accept, pending_vec, wb_error
  );
endinterface

// File: rtl/regfile_scoreboard_wb.sv
// Write-back register file with per-register pending-write counters.
// Reads bypass the same-cycle write-back; decode stalls on pending sources
// or on a destination whose counter would saturate.
module regfile_scoreboard_wb #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 2
) (
  input logic                  clk,
  input logic                  reset,
  regfile_scoreboard_wb_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] regs_q [32];
  logic [CNT_WIDTH-1:0]  cnt_q  [32];
  logic [CNT_WIDTH-1:0]  cnt_d  [32];
  logic [CNT_WIDTH-1:0]  eff    [32];
  logic [31:0]           pending_q, pending_d;
  logic                  wb_error_q, wb_error_d;

  logic                  wb_fire;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  src_hazard;
  logic                  dst_full;
  logic                  stall;
  logic                  accept;
  logic                  dst_fire;
  logic [DATA_WIDTH-1:0] rd1, rd2;

  // Write-back decode and per-register count after this cycle's release
  always_comb begin
    wb_fire = bus.wb_valid & bus.wb_reg_write & (bus.wb_addr != 5'd0);
    wb_data = bus.wb_mem_to_reg ? bus.mem_data_out : bus.alu_data_out;
    for (int unsigned i = 0; i < 32; i++) begin
      eff[i] = cnt_q[i];
      // A release against an empty counter leaves it at zero rather than wrapping.
      if (wb_fire && (bus.wb_addr == 5'(i)) && (cnt_q[i] != '0)) begin
        eff[i] = cnt_q[i] - CNT_ONE;
      end
    end
  end

  // Read ports with write-back bypass; r0 is hardwired to zero
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (bus.id_rs_addr != 5'd0) begin
      rd1 = (wb_fire && (bus.wb_addr == bus.id_rs_addr)) ? wb_data : regs_q[bus.id_rs_addr];
    end
    if (bus.id_rt_addr != 5'd0) begin
      rd2 = (wb_fire && (bus.wb_addr == bus.id_rt_addr)) ? wb_data : regs_q[bus.id_rt_addr];
    end
  end

  // Hazard detection and issue handshake
  always_comb begin
    src_hazard = bus.id_valid &
                 (((bus.id_rs_addr != 5'd0) && (eff[bus.id_rs_addr] != '0)) |
                  ((bus.id_rt_addr != 5'd0) && (eff[bus.id_rt_addr] != '0)));
    dst_full   = bus.id_valid & bus.id_reg_write & (bus.id_dst_addr != 5'd0) &
                 (eff[bus.id_dst_addr] == CNT_MAX);
    stall      = src_hazard | dst_full;
    accept     = bus.id_valid & ~stall;
    dst_fire   = accept & bus.id_reg_write & (bus.id_dst_addr != 5'd0);
  end

  // Counter next state: reserve on issue, release on write-back, never wrap
  always_comb begin
    for (int unsigned i = 0; i < 32; i++) begin
      logic inc;
      logic dec;
      inc = dst_fire && (bus.id_dst_addr == 5'(i));
      dec = wb_fire && (bus.wb_addr == 5'(i)) && (cnt_q[i] != '0);
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (dec && !inc) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
      pending_d[i] = (cnt_d[i] != '0);
    end
    wb_error_d = wb_error_q | (wb_fire & (cnt_q[bus.wb_addr] == '0));
  end

  // Register storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_fire) begin
      regs_q[bus.wb_addr] <= wb_data;
    end
  end

  // Scoreboard counters, pending vector and sticky error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) begin
        cnt_q[i] <= '0;
      end
      pending_q  <= '0;
      wb_error_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 32; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      pending_q  <= pending_d;
      wb_error_q <= wb_error_d;
    end
  end

  assign bus.reg_file_rd_data1 = rd1;
  assign bus.reg_file_rd_data2 = rd2;
  assign bus.hazard_stall      = stall;
  assign bus.issue_accept      = accept;
  assign bus.pending_vec       = pending_q;
  assign bus.wb_error          = wb_error_q;

endmodule

// File: tb/tb_regfile_scoreboard_wb.sv
// Directed bench for regfile_scoreboard_wb with hand-computed expectations.
module tb_regfile_scoreboard_wb;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  regfile_scoreboard_wb_if #(.DATA_WIDTH(32)) bus ();

  regfile_scoreboard_wb #(.DATA_WIDTH(32), .CNT_WIDTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.id_valid      = 1'b0;
    bus.id_rs_addr    = 5'd0;
    bus.id_rt_addr    = 5'd0;
    bus.id_dst_addr   = 5'd0;
    bus.id_reg_write  = 1'b0;
    bus.wb_valid      = 1'b0;
    bus.wb_reg_write  = 1'b0;
    bus.wb_mem_to_reg = 1'b0;
    bus.wb_addr       = 5'd0;
    bus.alu_data_out  = '0;
    bus.mem_data_out  = '0;
  endtask

  task automatic issue(input logic [4:0] dst);
    bus.id_valid     = 1'b1;
    bus.id_reg_write = 1'b1;
    bus.id_dst_addr  = dst;
  endtask

  task automatic wb(input logic [4:0] a, input logic m2r, input logic [31:0] alu, input logic [31:0] mem);
    bus.wb_valid      = 1'b1;
    bus.wb_reg_write  = 1'b1;
    bus.wb_mem_to_reg = m2r;
    bus.wb_addr       = a;
    bus.alu_data_out  = alu;
    bus.mem_data_out  = mem;
  endtask

  // Advance past the next rising edge; drive and sample land 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    idle();

    // Reset state with r5/r7 presented
    #2;
    bus.id_valid   = 1'b1;
    bus.id_rs_addr = 5'd5;
    bus.id_rt_addr = 5'd7;
    #1;
    chk("rst_rd1", bus.reg_file_rd_data1, 0);
    chk("rst_rd2", bus.reg_file_rd_data2, 0);
    chk("rst_stall", bus.hazard_stall, 0);
    chk("rst_pend", bus.pending_vec, 0);
    chk("rst_err", bus.wb_error, 0);
    #3 reset = 1'b1;

    // Reserve r3, then a dependent read stalls
    tick(); idle(); issue(5'd3);
    #1;
    chk("iss3_accept", bus.issue_accept, 1);
    tick(); idle();
    chk("pend3", bus.pending_vec, 64'h8);
    bus.id_valid = 1'b1; bus.id_rs_addr = 5'd3;
    #1;
    chk("raw3_stall", bus.hazard_stall, 1);
    chk("raw3_accept", bus.issue_accept, 0);

    // Write-back of r3 releases the hazard and bypasses data in the same cycle
    tick();
    wb(5'd3, 1'b0, 32'h1234, 32'hDEAD);
    #1;
    chk("byp3_stall", bus.hazard_stall, 0);
    chk("byp3_rd1", bus.reg_file_rd_data1, 32'h1234);
    tick(); idle();
    bus.id_valid = 1'b1; bus.id_rt_addr = 5'd3;
    #1;
    chk("pend3_clr", bus.pending_vec, 0);
    chk("store3_rd2", bus.reg_file_rd_data2, 32'h1234);
    chk("err_after3", bus.wb_error, 0);

    // wb_valid without reg_write is ignored
    tick(); idle();
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd5; bus.alu_data_out = 32'h55;
    tick(); idle();
    bus.id_valid = 1'b1; bus.id_rs_addr = 5'd5;
    #1;
    chk("nowr_rd", bus.reg_file_rd_data1, 0);
    chk("nowr_err", bus.wb_error, 0);

    // Three reservations of r4 saturate its counter
    tick(); idle(); issue(5'd4);
    tick(); issue(5'd4);
    tick(); issue(5'd4);
    #1;
    chk("r4_third_accept", bus.issue_accept, 1);
    tick(); idle(); issue(5'd4);
    #1;
    chk("r4_full_stall", bus.hazard_stall, 1);
    chk("r4_full_accept", bus.issue_accept, 0);
    chk("r4_pend", bus.pending_vec, 64'h10);

    // Reader of r4 stalls until the third write-back
    tick(); idle();
    bus.id_valid = 1'b1; bus.id_rs_addr = 5'd4;
    wb(5'd4, 1'b0, 32'h41, 32'h0);
    #1;
    chk("r4_wb1_stall", bus.hazard_stall, 1);
    tick(); wb(5'd4, 1'b0, 32'h42, 32'h0);
    #1;
    chk("r4_wb2_stall", bus.hazard_stall, 1);
    tick(); wb(5'd4, 1'b0, 32'h43, 32'h0);
    #1;
    chk("r4_wb3_stall", bus.hazard_stall, 0);
    chk("r4_wb3_rd", bus.reg_file_rd_data1, 32'h43);
    tick(); idle();
    chk("r4_pend_clr", bus.pending_vec, 0);
    chk("r4_err", bus.wb_error, 0);

    // Simultaneous reserve and release on r9 keeps the count at one
    issue(5'd9);
    tick(); idle();
    issue(5'd9);
    wb(5'd9, 1'b0, 32'h99, 32'h0);
    #1;
    chk("r9_same_accept", bus.issue_accept, 1);
    tick(); idle();
    bus.id_valid = 1'b1; bus.id_rs_addr = 5'd9;
    #1;
    chk("r9_pend", bus.pending_vec, 64'h200);
    chk("r9_src_stall", bus.hazard_stall, 1);
    chk("r9_err", bus.wb_error, 0);
    tick(); idle();
    wb(5'd9, 1'b0, 32'h9A, 32'h0);
    tick(); idle();
    chk("r9_pend_clr", bus.pending_vec, 0);

    // Write-back to r0 is dropped
    wb(5'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bus.id_valid = 1'b1;
    #1;
    chk("r0_byp_rd", bus.reg_file_rd_data1, 0);
    tick(); idle();
    bus.id_valid = 1'b1;
    #1;
    chk("r0_rd", bus.reg_file_rd_data1, 0);
    chk("r0_pend", bus.pending_vec, 0);
    chk("r0_err", bus.wb_error, 0);

    // Release of an unreserved register writes data and flags the error
    tick(); idle();
    wb(5'd6, 1'b1, 32'h1111, 32'hABCD);
    tick(); idle();
    bus.id_valid = 1'b1; bus.id_rs_addr = 5'd6;
    #1;
    chk("r6_rd", bus.reg_file_rd_data1, 32'hABCD);
    chk("r6_err", bus.wb_error, 1);
    chk("r6_pend", bus.pending_vec, 0);
    tick(); idle();
    chk("err_sticky", bus.wb_error, 1);

    // Mid-run reset drops a live reservation asynchronously
    issue(5'd10);
    tick(); idle();
    chk("r10_pend", bus.pending_vec, 64'h400);
    #2 reset = 1'b0;
    #1;
    bus.id_valid = 1'b1; bus.id_rs_addr = 5'd6;
    #1;
    chk("mrst_pend", bus.pending_vec, 0);
    chk("mrst_err", bus.wb_error, 0);
    chk("mrst_rd6", bus.reg_file_rd_data1, 0);
    chk("mrst_stall", bus.hazard_stall, 0);
    #2 reset = 1'b1;
    tick(); idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
